// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: the entry layout of the
// shadow pipeline that mirrors the E..W stages.
package fwd_pkg;

    localparam int unsigned TNEW_W = 2;
    localparam int unsigned STG_E  = 0;
    localparam int unsigned STG_M  = 1;
    localparam int unsigned STG_W  = 2;

    typedef struct packed {
        logic              valid;
        logic [4:0]        waddr;
        logic [TNEW_W-1:0] tnew;
    } fwd_entry_t;

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy counter: loads the unit latency on an accepted start and
// counts down to idle.
module md_busy_ctr #(
    parameter int unsigned MD_LAT  = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int unsigned MAX_LAT = (MD_LAT > DIV_LAT) ? MD_LAT : DIV_LAT;
    localparam int unsigned CTR_W   = $clog2(MAX_LAT + 1);

    logic [CTR_W-1:0] ctr;

    // A start while the unit is still busy is dropped rather than restarting it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctr <= '0;
        end else if (md_start && !md_busy) begin
            ctr <= md_is_div ? CTR_W'(DIV_LAT) : CTR_W'(MD_LAT);
        end else if (md_busy) begin
            ctr <= ctr - CTR_W'(1);
        end
    end

    assign md_busy = (ctr != '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding unit: shadows register writes in flight through E..W,
// raises the D-stage stall and returns forwarded operands per read port.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MD_LAT  = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic [4:0]             d_waddr,
    input  logic [TNEW_W-1:0]      d_tnew,
    input  logic                   d_md_use,
    input  logic [NUM_RD*5-1:0]    rd_addr,
    input  logic [NUM_RD*2-1:0]    rd_tuse,
    input  logic [NUM_RD*32-1:0]   grf_data,
    input  logic [DEPTH*32-1:0]    stage_data,
    input  logic                   md_start,
    input  logic                   md_is_div,
    output logic                   stall,
    output logic [NUM_RD*32-1:0]   fwd_data,
    output logic [NUM_RD*2-1:0]    fwd_sel,
    output logic                   md_busy
);

    fwd_entry_t        pipe [DEPTH];
    logic [NUM_RD-1:0] port_haz;
    logic              md_haz;

    // A stalled D injects a bubble into E; older entries age by one stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[STG_E] <= '{valid: d_valid & ~stall, waddr: d_waddr, tnew: d_tnew};
            for (int unsigned k = 1; k < DEPTH; k++) begin
                pipe[k] <= '{valid: pipe[k-1].valid,
                             waddr: pipe[k-1].waddr,
                             tnew:  tnew_dec(pipe[k-1].tnew)};
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [4:0]  addr;
        logic [1:0]  tuse;
        logic        hit;
        logic        haz;
        logic [1:0]  sel;
        logic [31:0] data;

        assign addr = rd_addr[p*5 +: 5];
        assign tuse = rd_tuse[p*2 +: 2];

        // Ascending search with a hit latch gives youngest-stage priority.
        always_comb begin
            hit  = 1'b0;
            haz  = 1'b0;
            sel  = '0;
            data = grf_data[p*32 +: 32];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!hit && pipe[k].valid && (pipe[k].waddr == addr) && (addr != '0)) begin
                    hit  = 1'b1;
                    haz  = (pipe[k].tnew > tuse);
                    sel  = 2'(k + 1);
                    data = stage_data[k*32 +: 32];
                end
            end
        end

        assign port_haz[p]            = haz;
        assign fwd_sel[p*2 +: 2]      = sel;
        assign fwd_data[p*32 +: 32]   = data;
    end

    md_busy_ctr #(
        .MD_LAT  (MD_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_ctr (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    assign md_haz = d_md_use & (md_busy | md_start);
    assign stall  = d_valid & ((|port_haz) | md_haz);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: a reference model of in-flight writes
// (by entry cycle) predicts each cycle's outputs; a monitor compares at negedge.
module tb_fwd_scoreboard;

    localparam int NUM_RD  = 2;
    localparam int DEPTH   = 3;
    localparam int MD_LAT  = 5;
    localparam int DIV_LAT = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  d_valid;
    logic [4:0]            d_waddr;
    logic [1:0]            d_tnew;
    logic                  d_md_use;
    logic [NUM_RD*5-1:0]   rd_addr;
    logic [NUM_RD*2-1:0]   rd_tuse;
    logic [NUM_RD*32-1:0]  grf_data;
    logic [DEPTH*32-1:0]   stage_data;
    logic                  md_start;
    logic                  md_is_div;
    logic                  stall;
    logic [NUM_RD*32-1:0]  fwd_data;
    logic [NUM_RD*2-1:0]   fwd_sel;
    logic                  md_busy;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .NUM_RD  (NUM_RD),
        .DEPTH   (DEPTH),
        .MD_LAT  (MD_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_waddr    (d_waddr),
        .d_tnew     (d_tnew),
        .d_md_use   (d_md_use),
        .rd_addr    (rd_addr),
        .rd_tuse    (rd_tuse),
        .grf_data   (grf_data),
        .stage_data (stage_data),
        .md_start   (md_start),
        .md_is_div  (md_is_div),
        .stall      (stall),
        .fwd_data   (fwd_data),
        .fwd_sel    (fwd_sel),
        .md_busy    (md_busy)
    );

    typedef struct {
        int enter;
        int waddr;
        int tnew;
    } inst_t;

    typedef struct {
        bit                    stall;
        bit                    busy;
        bit [NUM_RD-1:0]       fchk;
        logic [NUM_RD*2-1:0]   sel;
        logic [NUM_RD*32-1:0]  data;
    } exp_t;

    inst_t inflight[$];
    exp_t  exp_q[$];
    int    cyc = 0;
    bit    started = 0;
    bit    md_have = 0;
    int    md_s = 0;
    int    md_lat = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    logic                  s_stall;
    logic                  s_busy;
    logic [NUM_RD*2-1:0]   s_sel;
    logic [NUM_RD*32-1:0]  s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit md_busy_at(input int c);
        return md_have && (c > md_s) && (c <= md_s + md_lat);
    endfunction

    // Expected outputs for the current cycle, from the list of writes in flight.
    task automatic compute_exp(output exp_t e);
        bit anyhaz = 0;
        e.fchk = '0;
        e.sel  = '0;
        e.data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            int addr = int'(rd_addr[p*5 +: 5]);
            int tuse = int'(rd_tuse[p*2 +: 2]);
            int best = -1;
            int rem = 0;
            bit haz = 0;
            foreach (inflight[i]) begin
                int age = cyc - inflight[i].enter;
                if (addr != 0 && inflight[i].waddr == addr && (best < 0 || age < best)) begin
                    best = age;
                    rem  = inflight[i].tnew - age;
                end
            end
            if (rem < 0) rem = 0;
            if (best >= 0) begin
                haz = rem > tuse;
                e.sel[p*2 +: 2]   = 2'(best + 1);
                e.data[p*32 +: 32] = stage_data[best*32 +: 32];
            end else begin
                e.data[p*32 +: 32] = grf_data[p*32 +: 32];
            end
            e.fchk[p] = !haz;
            if (haz) anyhaz = 1;
        end
        e.busy  = md_busy_at(cyc);
        e.stall = d_valid && (anyhaz || (d_md_use && (e.busy || md_start)));
    endtask

    task automatic model_edge(input bit e_stall);
        if (!reset) begin
            inflight.delete();
            md_have = 0;
        end else begin
            if (md_start && !md_busy_at(cyc)) begin
                md_have = 1;
                md_s    = cyc;
                md_lat  = md_is_div ? DIV_LAT : MD_LAT;
            end
            if (d_valid && !e_stall)
                inflight.push_back('{enter: cyc + 1, waddr: int'(d_waddr), tnew: int'(d_tnew)});
        end
        cyc++;
        while (inflight.size() > 0 && cyc - inflight[0].enter >= DEPTH)
            void'(inflight.pop_front());
    endtask

    // One clock: predict, sample DUT mid-cycle, advance model at the edge.
    task automatic cycle_end();
        exp_t e;
        compute_exp(e);
        if (started) exp_q.push_back(e);
        #1;
        s_stall = stall;
        s_busy  = md_busy;
        s_sel   = fwd_sel;
        s_data  = fwd_data;
        @(posedge clk);
        model_edge(e.stall);
        started = 1;
        #1;
    endtask

    task automatic set_idle();
        reset     = 1'b1;
        d_valid   = 1'b0;
        d_waddr   = '0;
        d_tnew    = '0;
        d_md_use  = 1'b0;
        rd_addr   = '0;
        rd_tuse   = '0;
        md_start  = 1'b0;
        md_is_div = 1'b0;
        for (int p = 0; p < NUM_RD; p++) grf_data[p*32 +: 32] = $urandom;
        for (int k = 0; k < DEPTH; k++) stage_data[k*32 +: 32] = $urandom;
    endtask

    task automatic hold_until_release(input int maxc, output int nst);
        nst = 0;
        for (int i = 0; i < maxc; i++) begin
            cycle_end();
            if (s_stall) nst++;
            else break;
        end
    endtask

    task automatic flush();
        set_idle();
        repeat (4) cycle_end();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", 64'(stall), 64'(e.stall));
                check("md_busy", 64'(md_busy), 64'(e.busy));
                for (int p = 0; p < NUM_RD; p++) begin
                    if (e.fchk[p]) begin
                        check("fwd_sel", 64'(fwd_sel[p*2 +: 2]), 64'(e.sel[p*2 +: 2]));
                        check("fwd_data", 64'(fwd_data[p*32 +: 32]), 64'(e.data[p*32 +: 32]));
                    end
                end
            end
        end
    end

    initial begin : stim
        int nst;
        int nb;

        // Reset held two cycles with a valid D instruction.
        set_idle();
        reset = 1'b0;
        d_valid = 1'b1;
        d_waddr = 5'd4;
        d_tnew = 2'd2;
        rd_addr[4:0] = 5'd4;
        cycle_end();
        cycle_end();
        check("reset_stall", 64'(s_stall), 64'd0);
        check("reset_sel", 64'(s_sel), 64'd0);
        check("reset_busy", 64'(s_busy), 64'd0);
        flush();

        // ALU result feeding a branch comparator.
        set_idle();
        d_valid = 1'b1; d_waddr = 5'd3; d_tnew = 2'd1;
        cycle_end();
        set_idle();
        d_valid = 1'b1; rd_addr[4:0] = 5'd3; rd_tuse[1:0] = 2'd0;
        stage_data[63:32] = 32'h1234;
        hold_until_release(8, nst);
        check("alu_br_stalls", 64'(nst), 64'd1);
        check("alu_br_sel", 64'(s_sel[1:0]), 64'd2);
        check("alu_br_data", 64'(s_data[31:0]), 64'h1234);
        flush();

        // Load-use.
        set_idle();
        d_valid = 1'b1; d_waddr = 5'd5; d_tnew = 2'd2;
        cycle_end();
        set_idle();
        d_valid = 1'b1; rd_addr[9:5] = 5'd5; rd_tuse[3:2] = 2'd1;
        hold_until_release(8, nst);
        check("load_use_stalls", 64'(nst), 64'd1);
        flush();

        // Youngest-first priority and $0 never forwarded.
        set_idle();
        d_valid = 1'b1; d_waddr = 5'd0; d_tnew = 2'd0;
        cycle_end();
        d_waddr = 5'd7;
        cycle_end();
        cycle_end();
        set_idle();
        d_valid = 1'b1;
        rd_addr[4:0] = 5'd7;
        rd_addr[9:5] = 5'd0;
        stage_data[31:0]  = 32'hA;
        stage_data[63:32] = 32'hB;
        grf_data[63:32]   = 32'hC0FFEE;
        cycle_end();
        check("prio_stall", 64'(s_stall), 64'd0);
        check("prio_sel0", 64'(s_sel[1:0]), 64'd1);
        check("prio_data0", 64'(s_data[31:0]), 64'hA);
        check("zero_sel1", 64'(s_sel[3:2]), 64'd0);
        check("zero_data1", 64'(s_data[63:32]), 64'hC0FFEE);
        flush();

        // Divide then mult followed by HI/LO use.
        for (int v = 0; v < 2; v++) begin
            set_idle();
            d_valid = 1'b1; d_md_use = 1'b1; md_start = 1'b1; md_is_div = (v == 0);
            nst = 0; nb = 0;
            cycle_end();
            if (s_stall) nst++;
            md_start = 1'b0;
            for (int i = 0; i < 20; i++) begin
                cycle_end();
                if (s_busy) nb++;
                if (s_stall) nst++;
                else break;
            end
            check(v == 0 ? "div_stalls" : "mult_stalls", 64'(nst), v == 0 ? 64'd11 : 64'd6);
            check(v == 0 ? "div_busy" : "mult_busy", 64'(nb), v == 0 ? 64'd10 : 64'd5);
            flush();
        end

        // Reset during a load-use stall.
        set_idle();
        d_valid = 1'b1; d_waddr = 5'd5; d_tnew = 2'd2;
        cycle_end();
        set_idle();
        d_valid = 1'b1; rd_addr[4:0] = 5'd5; rd_addr[9:5] = 5'd5;
        cycle_end();
        check("mid_stall_before", 64'(s_stall), 64'd1);
        reset = 1'b0;
        cycle_end();
        reset = 1'b1;
        cycle_end();
        check("mid_rst_stall", 64'(s_stall), 64'd0);
        check("mid_rst_sel", 64'(s_sel), 64'd0);
        flush();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            reset     = ($urandom_range(0, 199) != 0);
            d_valid   = $urandom_range(0, 3) != 0;
            d_waddr   = 5'($urandom_range(0, 7));
            d_tnew    = 2'($urandom_range(0, 3));
            d_md_use  = $urandom_range(0, 7) == 0;
            md_start  = reset && ($urandom_range(0, 11) == 0);
            md_is_div = $urandom_range(0, 1) == 1;
            for (int p = 0; p < NUM_RD; p++) begin
                rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
                rd_tuse[p*2 +: 2] = 2'($urandom_range(0, 3));
            end
            cycle_end();
        end

        set_idle();
        repeat (2) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
